// File: rtl/rom_fetch_sequencer.sv
// ROM fetch sequencer: turns auto-scan ticks or manual steps into single ROM reads.
// It waits out the ROM latency, then holds the returned word for display.
module rom_fetch_sequencer #(
    parameter int unsigned NBITS_ADDR = 2,
    parameter int unsigned NBITS_DATA = 4,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  clr_ovr,
    input  logic [NBITS_ADDR-1:0] start_addr,
    input  logic [NBITS_ADDR-1:0] end_addr,
    input  logic [NBITS_DATA-1:0] rom_data,
    output logic [NBITS_ADDR-1:0] rom_addr,
    output logic                  rom_req,
    output logic [NBITS_DATA-1:0] data_out,
    output logic                  data_valid,
    output logic                  wrap,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                pending;
    logic                pending_nxt;
    logic                drop;
    logic                step_sync1;
    logic                step_sync2;
    logic                step_sync3;
    logic                step_edge;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic                trigger;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [NBITS_ADDR-1:0] addr_nxt;
    logic                wrap_nxt;

    // Two-flop synchroniser plus an edge flop for the raw step switch
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            step_sync1 <= 1'b0;
            step_sync2 <= 1'b0;
            step_sync3 <= 1'b0;
        end else begin
            step_sync1 <= step;
            step_sync2 <= step_sync1;
            step_sync3 <= step_sync2;
        end
    end

    assign step_edge = step_sync2 & ~step_sync3;
    assign tick      = run && (tick_cnt == TICK_LAST);
    assign trigger   = step_edge | tick;

    // Auto-scan divider, held at zero while not running
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (!run || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next address: an out-of-range address restarts the scan without flagging a wrap
    always_comb begin
        addr_nxt = rom_addr + NBITS_ADDR'(1);
        wrap_nxt = 1'b0;
        if (rom_addr == end_addr) begin
            addr_nxt = start_addr;
            wrap_nxt = 1'b1;
        end else if (rom_addr > end_addr) begin
            addr_nxt = start_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        drop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger || pending) begin
                    state_nxt   = ST_ISSUE;
                    pending_nxt = trigger & pending;
                end
            end
            ST_ISSUE:   state_nxt = (ROM_LAT > 1) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // One trigger can queue behind an active fetch; a second one is lost
        if ((state != ST_IDLE) && trigger) begin
            if (pending) begin
                drop = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            rom_addr   <= '0;
            rom_req    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            wrap       <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            rom_req    <= (state_nxt == ST_ISSUE);
            busy       <= (state_nxt != ST_IDLE);
            data_valid <= (state == ST_CAPTURE);
            wrap       <= (state == ST_CAPTURE) && wrap_nxt;
            if (state == ST_CAPTURE) begin
                data_out <= rom_data;
                rom_addr <= addr_nxt;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
